// File: rtl/vec_scalar_alu.sv
// Sequential vector-scalar ALU: latches one scalar and one N_ELEM vector, then
// walks the vector LANES elements per cycle and holds the result until it is taken.
module vec_scalar_alu_lane #(
    parameter int DATA_W = 32,
    parameter bit SAT_EN = 1'b1
) (
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] res_o,
    output logic              sat_o
);
    logic signed [DATA_W:0] a_x, b_x, diff, wide;

    assign a_x = {a_i[DATA_W-1], a_i};
    assign b_x = {b_i[DATA_W-1], b_i};

    // One guard bit is enough: no mode (abs included) can exceed DATA_W+1 signed bits.
    always_comb begin
        diff = a_x - b_x;
        case (mode_i)
            2'b00:   wide = diff;
            2'b01:   wide = b_x - a_x;
            2'b10:   wide = a_x + b_x;
            default: wide = diff[DATA_W] ? -diff : diff;
        endcase
        res_o = wide[DATA_W-1:0];
        sat_o = 1'b0;
        if (SAT_EN && (wide[DATA_W] != wide[DATA_W-1])) begin
            sat_o = 1'b1;
            res_o = wide[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end
endmodule

module vec_scalar_alu #(
    parameter int DATA_W = 32,
    parameter int N_ELEM = 8,
    parameter int LANES  = 4,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               mode,
    input  logic [DATA_W-1:0]        scalar,
    input  logic [N_ELEM*DATA_W-1:0] vec_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_ELEM*DATA_W-1:0] vec_out,
    output logic                     sat_flag,
    output logic                     busy
);
    localparam int P  = (N_ELEM + LANES - 1) / LANES;
    localparam int CW = (P > 1) ? $clog2(P) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [1:0]               mode_q, mode_d;
    logic [DATA_W-1:0]        scalar_q, scalar_d;
    logic [N_ELEM*DATA_W-1:0] vec_q, vec_d;
    logic [N_ELEM*DATA_W-1:0] vec_out_q, vec_out_d;
    logic                     sat_q, sat_d;

    logic [P*LANES*DATA_W-1:0]       vec_pad;
    logic [LANES-1:0][DATA_W-1:0]    lane_b, lane_res;
    logic [LANES-1:0]                lane_sat;

    // Zero-pad so the last chunk can always be sliced at full LANES width.
    always_comb begin
        vec_pad = '0;
        vec_pad[N_ELEM*DATA_W-1:0] = vec_q;
    end

    always_comb lane_b = vec_pad[int'(cnt_q)*LANES*DATA_W +: LANES*DATA_W];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        vec_scalar_alu_lane #(.DATA_W(DATA_W), .SAT_EN(SAT_EN)) u_lane (
            .mode_i (mode_q),
            .a_i    (scalar_q),
            .b_i    (lane_b[l]),
            .res_o  (lane_res[l]),
            .sat_o  (lane_sat[l])
        );
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        scalar_d  = scalar_q;
        vec_d     = vec_q;
        vec_out_d = vec_out_q;
        sat_d     = sat_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d   = mode;
                    scalar_d = scalar;
                    vec_d    = vec_in;
                    sat_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Padding lanes of the final chunk neither write nor flag.
                for (int l = 0; l < LANES; l++) begin
                    if (int'(cnt_q)*LANES + l < N_ELEM) begin
                        vec_out_d[(int'(cnt_q)*LANES + l)*DATA_W +: DATA_W] = lane_res[l];
                        if (lane_sat[l]) sat_d = 1'b1;
                    end
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(P-1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mode_q    <= '0;
            scalar_q  <= '0;
            vec_q     <= '0;
            vec_out_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            scalar_q  <= scalar_d;
            vec_q     <= vec_d;
            vec_out_q <= vec_out_d;
            sat_q     <= sat_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign vec_out   = vec_out_q;
    assign sat_flag  = sat_q;
endmodule

// File: tb/tb_vec_scalar_alu.sv
// Directed bench for vec_scalar_alu: three builds (LANES=4 sat, LANES=3 sat,
// LANES=5 wrap) share one stimulus stream and are checked against hand-derived tables.
module tb_vec_scalar_alu;
    localparam int W = 32;
    localparam int N = 8;
    localparam int NV = 8;
    localparam logic [31:0] MX = 32'h7FFFFFFF;
    localparam logic [31:0] MN = 32'h80000000;
    localparam logic [31:0] M1 = 32'hFFFFFFFF;

    typedef struct {
        logic [1:0]     mode;
        logic [W-1:0]   scalar;
        logic [N*W-1:0] vin;
        logic [N*W-1:0] exp_s;
        logic           sat_s;
        logic [N*W-1:0] exp_w;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [1:0]     mode = '0;
    logic [W-1:0]   scalar = '0;
    logic [N*W-1:0] vec_in = '0;
    wire  [2:0]     ir, ov, sf, bz;
    wire  [N*W-1:0] vo [3];

    int checks = 0, failures = 0;
    int pexp [3] = '{2, 3, 2};
    vec_t tbl [NV];

    always #5 clk = ~clk;

    vec_scalar_alu #(.DATA_W(W), .N_ELEM(N), .LANES(4), .SAT_EN(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .mode(mode),
        .scalar(scalar), .vec_in(vec_in), .out_valid(ov[0]), .out_ready(out_ready),
        .vec_out(vo[0]), .sat_flag(sf[0]), .busy(bz[0]));
    vec_scalar_alu #(.DATA_W(W), .N_ELEM(N), .LANES(3), .SAT_EN(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .mode(mode),
        .scalar(scalar), .vec_in(vec_in), .out_valid(ov[1]), .out_ready(out_ready),
        .vec_out(vo[1]), .sat_flag(sf[1]), .busy(bz[1]));
    vec_scalar_alu #(.DATA_W(W), .N_ELEM(N), .LANES(5), .SAT_EN(1'b0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .mode(mode),
        .scalar(scalar), .vec_in(vec_in), .out_valid(ov[2]), .out_ready(out_ready),
        .vec_out(vo[2]), .sat_flag(sf[2]), .busy(bz[2]));

    function automatic logic [N*W-1:0] pk(input logic [31:0] e0, e1, e2, e3, e4, e5, e6, e7);
        return {e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] exp_for(input int d, input int i);
        return (d == 2) ? tbl[i].exp_w : tbl[i].exp_s;
    endfunction

    task automatic do_txn(input int i);
        bit             got [3];
        int             lat [3];
        logic [N*W-1:0] cap [3];
        logic           cs  [3];
        for (int d = 0; d < 3; d++) begin got[d] = 1'b0; lat[d] = 0; cap[d] = '0; cs[d] = 1'b0; end
        mode = tbl[i].mode; scalar = tbl[i].scalar; vec_in = tbl[i].vin; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after accept: the in-flight transaction must not see them.
        in_valid = 1'b0; mode = ~mode; scalar = ~scalar; vec_in = ~vec_in;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (got[d] && n == lat[d] + 1)
                    chk($sformatf("handoff_d%0d_v%0d", d, i), {ir[d], ov[d]}, 2'b10);
                else if (!got[d] && ov[d]) begin
                    got[d] = 1'b1; lat[d] = n; cap[d] = vo[d]; cs[d] = sf[d];
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            if (!got[d]) chk($sformatf("timeout_d%0d_v%0d", d, i), 0, 1);
            else begin
                chk($sformatf("latency_d%0d_v%0d", d, i), lat[d], pexp[d]);
                chk($sformatf("vec_d%0d_v%0d", d, i), cap[d], exp_for(d, i));
                chk($sformatf("sat_d%0d_v%0d", d, i), cs[d], (d == 2) ? 1'b0 : tbl[i].sat_s);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{2'd0, 32'd10, pk(0, 1, 2, 3, 4, 5, 6, 7),
                   pk(10, 9, 8, 7, 6, 5, 4, 3), 1'b0, pk(10, 9, 8, 7, 6, 5, 4, 3)};
        tbl[1] = '{2'd1, 32'd5, pk(0, 100, 200, 300, 400, 500, 600, 700),
                   pk(-5, 95, 195, 295, 395, 495, 595, 695), 1'b0,
                   pk(-5, 95, 195, 295, 395, 495, 595, 695)};
        tbl[2] = '{2'd0, MX, pk(0, 0, 0, -1, 0, 0, 0, 0),
                   pk(MX, MX, MX, MX, MX, MX, MX, MX), 1'b1, pk(MX, MX, MX, MN, MX, MX, MX, MX)};
        tbl[3] = '{2'd3, -32'sd4, pk(6, -10, 0, 0, 0, 0, 0, 0),
                   pk(10, 6, 4, 4, 4, 4, 4, 4), 1'b0, pk(10, 6, 4, 4, 4, 4, 4, 4)};
        tbl[4] = '{2'd2, -32'sd4, pk(6, 0, 0, 0, 0, 0, 0, 0),
                   pk(2, -4, -4, -4, -4, -4, -4, -4), 1'b0, pk(2, -4, -4, -4, -4, -4, -4, -4)};
        tbl[5] = '{2'd2, MN, pk(-1, -1, -1, -1, -1, -1, -1, -1),
                   pk(MN, MN, MN, MN, MN, MN, MN, MN), 1'b1, pk(MX, MX, MX, MX, MX, MX, MX, MX)};
        tbl[6] = '{2'd3, MN, pk(MX, 0, 0, 0, 0, 0, 0, 0),
                   pk(MX, MX, MX, MX, MX, MX, MX, MX), 1'b1, pk(M1, MN, MN, MN, MN, MN, MN, MN)};
        tbl[7] = '{2'd1, 32'd1, pk(MN, 0, 0, 0, 0, 0, 0, 0),
                   pk(MN, -1, -1, -1, -1, -1, -1, -1), 1'b1, pk(MX, -1, -1, -1, -1, -1, -1, -1)};

        #12;
        chk("reset_in_ready", ir, 3'b111);
        chk("reset_out_valid", ov, 3'b000);
        chk("reset_busy", bz, 3'b000);
        chk("reset_sat", sf, 3'b000);
        for (int d = 0; d < 3; d++) chk($sformatf("reset_vec_d%0d", d), vo[d], '0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) do_txn(i);

        // Backpressure: result must hold while DONE and out_ready low.
        out_ready = 1'b0;
        mode = tbl[1].mode; scalar = tbl[1].scalar; vec_in = tbl[1].vin; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        for (int k = 0; k < 10 && ov !== 3'b111; k++) begin @(posedge clk); #1; end
        chk("bp_all_done", ov, 3'b111);
        for (int d = 0; d < 3; d++) chk($sformatf("bp_vec_d%0d", d), vo[d], exp_for(d, 1));
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            vec_in = {8{$urandom()}};
            mode = c[1:0];
            @(posedge clk); #1;
            chk($sformatf("bp_valid_c%0d", c), ov, 3'b111);
            chk($sformatf("bp_ready_c%0d", c), ir, 3'b000);
            chk($sformatf("bp_busy_c%0d", c), bz, 3'b111);
            for (int d = 0; d < 3; d++) chk($sformatf("bp_hold_d%0d_c%0d", d, c), vo[d], exp_for(d, 1));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", ov, 3'b000);
        chk("bp_release_ready", ir, 3'b111);
        do_txn(3);

        // Reset during RUN drops the transaction immediately.
        mode = tbl[0].mode; scalar = tbl[0].scalar; vec_in = tbl[0].vin; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        chk("midrun_busy", bz, 3'b111);
        @(negedge clk); rst_n = 1'b0; #1;
        chk("midrun_rst_ready", ir, 3'b111);
        chk("midrun_rst_valid", ov, 3'b000);
        chk("midrun_rst_busy", bz, 3'b000);
        chk("midrun_rst_sat", sf, 3'b000);
        for (int d = 0; d < 3; d++) chk($sformatf("midrun_rst_vec_d%0d", d), vo[d], '0);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post_rst_no_valid_c%0d", c), ov, 3'b000);
        end
        do_txn(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
